// File: rtl/p2s_engine.sv
// Parallel-to-serial shifter driving an external shift register (clear, DIV-paced s_clk, latch strobe).
// Acceptance to done = (CLR_BEFORE ? DIV : 0) + 2*DIV*DATA_BITS + DIV cycles; start edges while busy are dropped.
module p2s_engine #(
    parameter int DATA_BITS  = 64,
    parameter int DIV        = 2,
    parameter int MSB_FIRST  = 1,
    parameter int CLR_BEFORE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] p_data,
    output logic                 s_clk,
    output logic                 s_clrn,
    output logic                 sout,
    output logic                 s_latch,
    output logic                 EN,
    output logic                 done
);

    localparam int DW = $clog2(DIV + 1);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        FINISH
    } state_t;

    state_t                 state_q, state_d;
    logic                   start_q;
    logic [DATA_BITS-1:0]   sh_q, sh_d;
    logic [DW-1:0]          div_q, div_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic                   sout_q, sout_d;
    logic                   div_last;
    logic [DATA_BITS-1:0]   sh_next;

    function automatic logic send_bit(input logic [DATA_BITS-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_BITS-1] : w[0];
    endfunction

    assign div_last = (div_q == DIV_LAST);
    assign sh_next  = (MSB_FIRST != 0) ? {sh_q[DATA_BITS-2:0], 1'b0}
                                       : {1'b0, sh_q[DATA_BITS-1:1]};

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sout_d  = sout_q;
        case (state_q)
            IDLE: begin
                if (start && !start_q) begin
                    sh_d    = p_data;
                    bit_d   = '0;
                    div_d   = '0;
                    state_d = (CLR_BEFORE != 0) ? CLEAR : SHIFT_LO;
                end
            end
            CLEAR: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = SHIFT_LO;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            SHIFT_LO: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = SHIFT_HI;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            SHIFT_HI: begin
                if (div_last) begin
                    div_d   = '0;
                    sh_d    = sh_next;
                    bit_d   = bit_q + 1'b1;
                    state_d = (bit_q == BIT_LAST) ? LATCH : SHIFT_LO;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            LATCH: begin
                if (div_last) begin
                    div_d   = '0;
                    state_d = FINISH;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // sout only moves as s_clk falls, keeping each bit stable across its rising edge
        if (state_d == SHIFT_LO && state_q != SHIFT_LO) begin
            sout_d = send_bit(sh_d);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            start_q <= 1'b1;
            sh_q    <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            sout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start;
            sh_q    <= sh_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sout_q  <= sout_d;
        end
    end

    assign s_clk   = (state_q != SHIFT_LO);
    assign s_clrn  = (state_q != CLEAR);
    assign s_latch = (state_q == LATCH);
    assign EN      = (state_q == IDLE) || (state_q == FINISH);
    assign done    = (state_q == FINISH);
    assign sout    = sout_q;

endmodule

// File: tb/tb_p2s_engine.sv
// Bench for p2s_engine: three configurations checked every cycle against a waveform model plus literal expectations.
module tb_p2s_engine;

    localparam int N = 8;

    logic       clk;
    logic       rst;
    logic [2:0] start;
    logic [7:0] p_data [3];
    logic [2:0] s_clk_w, s_clrn_w, sout_w, s_latch_w, en_w, done_w;

    int checks   = 0;
    int failures = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    p2s_engine #(.DATA_BITS(8), .DIV(2), .MSB_FIRST(1), .CLR_BEFORE(1)) u_msb (
        .clk(clk), .rst(rst), .start(start[0]), .p_data(p_data[0]),
        .s_clk(s_clk_w[0]), .s_clrn(s_clrn_w[0]), .sout(sout_w[0]),
        .s_latch(s_latch_w[0]), .EN(en_w[0]), .done(done_w[0]));

    p2s_engine #(.DATA_BITS(8), .DIV(2), .MSB_FIRST(0), .CLR_BEFORE(1)) u_lsb (
        .clk(clk), .rst(rst), .start(start[1]), .p_data(p_data[1]),
        .s_clk(s_clk_w[1]), .s_clrn(s_clrn_w[1]), .sout(sout_w[1]),
        .s_latch(s_latch_w[1]), .EN(en_w[1]), .done(done_w[1]));

    p2s_engine #(.DATA_BITS(8), .DIV(1), .MSB_FIRST(1), .CLR_BEFORE(0)) u_fast (
        .clk(clk), .rst(rst), .start(start[2]), .p_data(p_data[2]),
        .s_clk(s_clk_w[2]), .s_clrn(s_clrn_w[2]), .sout(sout_w[2]),
        .s_latch(s_latch_w[2]), .EN(en_w[2]), .done(done_w[2]));

    function automatic int dv(input int id);
        return (id == 2) ? 1 : 2;
    endfunction

    function automatic int off(input int id);
        return (id == 2) ? 0 : 2;
    endfunction

    function automatic int lat_of(input int id);
        return off(id) + 2 * dv(id) * N + dv(id);
    endfunction

    function automatic logic bitval(input int id, input logic [7:0] d, input int i);
        return (id == 1) ? d[i] : d[N-1-i];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: k = clk edges since the accepting edge; waveform derived from k arithmetically.
    bit         mbusy       [3] = '{0, 0, 0};
    int         mk          [3] = '{0, 0, 0};
    logic [7:0] mdata       [3];
    logic       mstart_prev [3] = '{1'b1, 1'b1, 1'b1};
    logic       mlast       [3] = '{1'b0, 1'b0, 1'b0};
    bit         idle_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int id = 0; id < 3; id++) begin
                mbusy[id]       = 0;
                mk[id]          = 0;
                mstart_prev[id] = 1'b1;
                mlast[id]       = 1'b0;
            end
        end else begin
            for (int id = 0; id < 3; id++) begin
                idle_b = !mbusy[id];
                if (mbusy[id]) begin
                    mk[id]++;
                    if (mk[id] > lat_of(id)) begin
                        mbusy[id] = 0;
                        mlast[id] = bitval(id, mdata[id], N - 1);
                    end
                end
                if (idle_b && start[id] && !mstart_prev[id]) begin
                    mbusy[id] = 1;
                    mk[id]    = 0;
                    mdata[id] = p_data[id];
                end
                mstart_prev[id] = start[id];
            end
        end
    end

    // Packed as {EN, done, s_clk, s_clrn, s_latch, sout}
    function automatic logic [5:0] expect_out(input int id);
        int k, j, o, d;
        o = off(id);
        d = dv(id);
        k = mk[id];
        if (!mbusy[id])                  return {5'b10110, mlast[id]};
        if (k < o)                       return {5'b00100, mlast[id]};
        if (k < o + 2 * d * N) begin
            j = k - o;
            return {2'b00, ((j % (2 * d)) >= d), 2'b10, bitval(id, mdata[id], j / (2 * d))};
        end
        if (k < lat_of(id))              return {5'b00111, bitval(id, mdata[id], N - 1)};
        return {5'b11110, bitval(id, mdata[id], N - 1)};
    endfunction

    int         rises    [3] = '{0, 0, 0};
    int         clrn_lo  [3] = '{0, 0, 0};
    int         latch_hi [3] = '{0, 0, 0};
    int         done_cnt [3] = '{0, 0, 0};
    logic [7:0] cap      [3] = '{8'h0, 8'h0, 8'h0};
    logic       prev_sclk[3] = '{1'b1, 1'b1, 1'b1};

    initial begin
        forever begin
            @(negedge clk);
            for (int id = 0; id < 3; id++) begin
                check($sformatf("wave%0d", id),
                      {26'd0, en_w[id], done_w[id], s_clk_w[id], s_clrn_w[id], s_latch_w[id], sout_w[id]},
                      {26'd0, expect_out(id)});
                if (!prev_sclk[id] && s_clk_w[id]) begin
                    rises[id]++;
                    cap[id] = {cap[id][6:0], sout_w[id]};
                end
                prev_sclk[id] = s_clk_w[id];
                if (!s_clrn_w[id]) clrn_lo[id]++;
                if (s_latch_w[id]) latch_hi[id]++;
                if (done_w[id])    done_cnt[id]++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end (t=%0t)", $time);
        $fatal(1);
    end

    // Called at #1 after a posedge; returns at #1 after the edge that raised done.
    task automatic xfer(input int id, input logic [7:0] d, output int lat);
        p_data[id] = d;
        start[id]  = 1'b1;
        @(posedge clk);
        #1;
        start[id]  = 1'b0;
        p_data[id] = ~d;
        lat = 0;
        while (done_w[id] !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int lat, r0, c0, l0, d0;

    initial begin
        rst       = 1'b1;
        start     = 3'b000;
        p_data[0] = 8'h00;
        p_data[1] = 8'h00;
        p_data[2] = 8'h00;
        tick(3);
        check("rst_en",     {29'd0, en_w},      32'h7);
        check("rst_done",   {29'd0, done_w},    32'h0);
        check("rst_sclk",   {29'd0, s_clk_w},   32'h7);
        check("rst_clrn",   {29'd0, s_clrn_w},  32'h7);
        check("rst_latch",  {29'd0, s_latch_w}, 32'h0);
        check("rst_sout",   {29'd0, sout_w},    32'h0);
        rst = 1'b0;
        tick(2);

        // MSB first, 0xC1
        r0 = rises[0]; c0 = clrn_lo[0]; l0 = latch_hi[0]; d0 = done_cnt[0];
        xfer(0, 8'hC1, lat);
        check("msb_latency", lat, 36);
        check("msb_en_at_done", {31'd0, en_w[0]}, 1);
        start[0] = 1'b1;                 // edge during FINISH must be ignored
        tick(1);
        start[0] = 1'b0;
        tick(6);
        check("msb_bits",   {24'd0, cap[0]}, 32'hC1);
        check("msb_rises",  rises[0] - r0, 8);
        check("msb_clrn",   clrn_lo[0] - c0, 2);
        check("msb_latch",  latch_hi[0] - l0, 2);
        check("msb_done",   done_cnt[0] - d0, 1);

        // LSB first, 0xC1 -> 1,0,0,0,0,0,1,1
        r0 = rises[1];
        xfer(1, 8'hC1, lat);
        check("lsb_latency", lat, 36);
        tick(2);
        check("lsb_bits",  {24'd0, cap[1]}, 32'h83);
        check("lsb_rises", rises[1] - r0, 8);

        // start held high 100 cycles
        r0 = rises[0]; d0 = done_cnt[0];
        p_data[0] = 8'h6B;
        start[0]  = 1'b1;
        tick(100);
        start[0]  = 1'b0;
        tick(2);
        check("hold_rises", rises[0] - r0, 8);
        check("hold_done",  done_cnt[0] - d0, 1);
        check("hold_bits",  {24'd0, cap[0]}, 32'h6B);

        // second start edge during bit 4 is dropped
        r0 = rises[0]; d0 = done_cnt[0];
        p_data[0] = 8'h5A;
        start[0]  = 1'b1;
        tick(1);
        start[0]  = 1'b0;
        tick(19);
        start[0]  = 1'b1;
        tick(1);
        start[0]  = 1'b0;
        tick(40);
        check("busy_rises", rises[0] - r0, 8);
        check("busy_done",  done_cnt[0] - d0, 1);
        check("busy_bits",  {24'd0, cap[0]}, 32'h5A);

        // asynchronous reset during bit 3
        d0 = done_cnt[0]; l0 = latch_hi[0];
        p_data[0] = 8'hA7;
        start[0]  = 1'b1;
        tick(1);
        start[0]  = 1'b0;
        tick(14);
        #2 rst = 1'b1;
        #1;
        check("arst_out0", {26'd0, en_w[0], done_w[0], s_clk_w[0], s_clrn_w[0], s_latch_w[0], sout_w[0]},
              32'b101100);
        tick(1);
        rst = 1'b0;
        tick(3);
        check("arst_nodone",  done_cnt[0] - d0, 0);
        check("arst_nolatch", latch_hi[0] - l0, 0);
        r0 = rises[0];
        xfer(0, 8'hA7, lat);
        check("arst_latency", lat, 36);
        tick(2);
        check("arst_bits",  {24'd0, cap[0]}, 32'hA7);
        check("arst_rises", rises[0] - r0, 8);

        // DIV=1, no clear, back-to-back
        r0 = rises[2];
        xfer(2, 8'h96, lat);
        check("fast_latency1", lat, 17);
        tick(1);
        xfer(2, 8'h3C, lat);
        check("fast_latency2", lat, 17);
        tick(2);
        check("fast_bits",  {24'd0, cap[2]}, 32'h3C);
        check("fast_rises", rises[2] - r0, 16);

        // start held across reset release
        rst      = 1'b1;
        start[0] = 1'b1;
        tick(1);
        rst = 1'b0;
        r0 = rises[0];
        tick(10);
        check("rsthold_rises", rises[0] - r0, 0);
        check("rsthold_en", {31'd0, en_w[0]}, 1);
        start[0] = 1'b0;
        tick(1);
        xfer(0, 8'h81, lat);
        check("rsthold_latency", lat, 36);
        tick(2);
        check("rsthold_bits", {24'd0, cap[0]}, 32'h81);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/p2s_engine.md
P2S_ENGINE -- requirements
Module: p2s_engine

Interface
REQ-001 Parameter DATA_BITS, default 64, word length shifted per transfer; legal values >= 2.
REQ-002 Parameter DIV, default 2, clk cycles per s_clk half-period; legal values >= 1.
REQ-003 Parameter MSB_FIRST, default 1; 1 = p_data[DATA_BITS-1] sent first, 0 = p_data[0] sent first.
REQ-004 Parameter CLR_BEFORE, default 1; 1 = pulse s_clrn low before shifting, 0 = no clear pulse.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset: asynchronous, active-high.
REQ-007 start  input  1  transfer request; acted on at its rising edge only.
REQ-008 p_data  input  DATA_BITS  parallel word; captured on transfer acceptance.
REQ-009 s_clk  output  1  serial clock to the external shift register; idle high; receiver samples sout on the s_clk rising edge.
REQ-010 s_clrn  output  1  active-low clear to the external shift register.
REQ-011 sout  output  1  serial data.
REQ-012 s_latch  output  1  output-latch strobe to the external register, active-high.
REQ-013 EN  output  1  idle/ready, 1 = no transfer in progress.
REQ-014 done  output  1  one-cycle pulse at the end of each transfer.

Function
REQ-015 Edge detection: start is registered as start_q; a transfer is accepted at a clk edge where start=1, start_q=0 and state=IDLE.
REQ-016 On acceptance: p_data loads into the internal shift register, EN<=0, bit counter<=0, next state CLEAR if CLR_BEFORE=1, otherwise SHIFT_LO.
REQ-017 States: IDLE, CLEAR, SHIFT_LO, SHIFT_HI, LATCH, FINISH; encoding is free.
REQ-018 CLEAR: s_clrn=0 and s_clk=1 for exactly DIV cycles, then SHIFT_LO.
REQ-019 SHIFT_LO: s_clk=0 for DIV cycles; on entry sout presents the current bit.
REQ-020 SHIFT_HI: s_clk=1 for DIV cycles; sout stays stable throughout.
REQ-021 Leaving SHIFT_HI: the shift register shifts one place toward the send end and the counter increments; if counter=DATA_BITS-1 go to LATCH, else go to SHIFT_LO.
REQ-022 sout changes only on entry to SHIFT_LO, so each bit is stable one full s_clk period around its rising edge.
REQ-023 LATCH: s_latch=1 and s_clk=1 for DIV cycles, then FINISH.
REQ-024 FINISH: done=1 and EN=1 for exactly one cycle, then IDLE.
REQ-025 Latency from the acceptance edge to done high = (CLR_BEFORE ? DIV : 0) + 2*DIV*DATA_BITS + DIV cycles.
REQ-026 Exactly DATA_BITS s_clk rising edges occur per transfer.
REQ-027 Outside CLEAR, s_clrn=1; outside SHIFT_LO, s_clk=1; outside LATCH, s_latch=0.
REQ-028 Boundary conditions:
- A start edge while EN=0 is ignored and not queued.
- start held high produces one transfer only.
- p_data changes while busy have no effect.
- A start edge in the FINISH cycle is ignored.
- A start edge on the cycle after FINISH is accepted (back-to-back).
REQ-029 The divider counter is a $clog2(DIV+1)-bit field; the bit counter is a $clog2(DATA_BITS+1)-bit field; neither wraps within a transfer.
REQ-030 In IDLE, sout holds the last bit sent (0 after reset).

Reset
REQ-031 rst=1 immediately forces, with no clk edge needed: state=IDLE, EN=1, done=0, s_clk=1, s_clrn=1, s_latch=0, sout=0, shift register=0, counters=0.
REQ-032 rst sets start_q=1, so a start held high through reset release does not launch a transfer; a fresh rising edge is required.
REQ-033 rst mid-transfer aborts it with no done pulse and no s_latch; the next accepted start sends a complete word.

Verification
REQ-034 DATA_BITS=8, DIV=2, MSB_FIRST=1, CLR_BEFORE=1, p_data=8'hC1, one start pulse:
- s_clrn low 2 cycles.
- sout at the 8 s_clk rising edges = 1,1,0,0,0,0,0,1.
- s_latch high 2 cycles.
- done high 36 cycles after acceptance; EN returns to 1 in that same cycle.
REQ-035 Same setup with MSB_FIRST=0, p_data=8'hC1: sout at the rising edges = 1,0,0,0,0,0,1,1.
REQ-036 start held high 100 cycles, then a second start edge at bit 4 of the transfer: exactly one transfer, 8 rising edges, one done pulse.
REQ-037 rst asserted asynchronously between clk edges during bit 3: all outputs take reset values before the next clk edge, no done or s_latch occurs, and the next start sends all 8 bits correctly.
REQ-038 DIV=1, CLR_BEFORE=0, start re-asserted on the cycle after done: second transfer accepted, done 17 cycles after its acceptance, 8 rising edges, each s_clk phase exactly 1 cycle.
REQ-039 start held high across rst release: no transfer until start falls and rises again.
